// File: rtl/brisc_ooo_pkg.sv
// Shared out-of-order core types: queue entry layout, register-file constants, hazard helpers.
package brisc_ooo_pkg;

   localparam int REG_IDX_W      = 5;
   localparam int NUM_REGS       = 32;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_BITS  = 20;

   function automatic int packet_width(input int data_width, input int address_bits);
      return data_width + 3 * address_bits + 38;
   endfunction

   localparam int ENTRY_PACKET_W = packet_width(DEF_DATA_WIDTH, DEF_ADDR_BITS);

   typedef struct packed {
      logic                        valid;
      logic [ENTRY_PACKET_W-1:0]   packet;
      logic [REG_IDX_W-1:0]        rs1;
      logic [REG_IDX_W-1:0]        rs2;
      logic [REG_IDX_W-1:0]        rd;
      logic                        use_rs1;
      logic                        use_rs2;
      logic                        write_rd;
   } entry_t;

   // Use flags are already cleared for x0, so a plain index compare is sufficient.
   function automatic logic reads_reg(input entry_t e, input logic [REG_IDX_W-1:0] r);
      return (e.use_rs1 && e.rs1 == r) || (e.use_rs2 && e.rs2 == r);
   endfunction

   function automatic logic order_conflict(input entry_t older, input entry_t younger);
      logic raw, waw, war;
      raw = older.write_rd && reads_reg(younger, older.rd);
      waw = older.write_rd && younger.write_rd && older.rd == younger.rd;
      war = younger.write_rd && reads_reg(older, younger.rd);
      return older.valid && (raw || waw || war);
   endfunction

endpackage

// File: rtl/issue_select.sv
// Oldest-first picker: one-hot grant of the lowest-index ready entry.
// Latency: combinational. Backpressure: none, pure function of the ready vector.
// Any_ready flags that at least one entry can issue this cycle.
module issue_select #(
   parameter int DEPTH = 8
) (
   input  logic [DEPTH-1:0] ready_vec,
   output logic [DEPTH-1:0] grant,
   output logic             any_ready
);

   assign grant     = ready_vec & ~(ready_vec - DEPTH'(1));
   assign any_ready = |ready_vec;

endmodule

// File: rtl/issue_queue_scheduler.sv
// Collapsing issue queue: issues the oldest hazard-free op, tracks a busy scoreboard.
// Latency: dispatch to earliest issue 1 cycle; writeback wakeup visible the next cycle.
// Backpressure: dispatch_ready drops at count == DEPTH; issue holds until issue_ready.
module issue_queue_scheduler
   import brisc_ooo_pkg::*;
#(
   parameter  int DATA_WIDTH   = 32,
   parameter  int ADDRESS_BITS = 20,
   parameter  int DEPTH        = 8,
   localparam int PACKET_WIDTH = packet_width(DATA_WIDTH, ADDRESS_BITS),
   localparam int COUNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    dispatch_valid,
   output logic                    dispatch_ready,
   input  logic [PACKET_WIDTH-1:0] dispatch_packet,
   input  logic [REG_IDX_W-1:0]    dispatch_rs1,
   input  logic [REG_IDX_W-1:0]    dispatch_rs2,
   input  logic [REG_IDX_W-1:0]    dispatch_rd,
   input  logic                    dispatch_use_rs1,
   input  logic                    dispatch_use_rs2,
   input  logic                    dispatch_write_rd,
   output logic                    issue_valid,
   input  logic                    issue_ready,
   output logic [PACKET_WIDTH-1:0] issue_packet,
   input  logic                    wb_valid,
   input  logic [REG_IDX_W-1:0]    wb_rd,
   input  logic                    flush,
   output logic [COUNT_W-1:0]      queue_count
);

   entry_t                entries_q [DEPTH];
   entry_t                entries_n [DEPTH];
   logic [COUNT_W-1:0]    count_q, count_n, ins_idx;
   logic [NUM_REGS-1:0]   busy_q, busy_n;
   logic [DEPTH-1:0]      ready_vec, grant, shift;
   logic                  any_ready, issue_fire, dispatch_fire, carry;
   entry_t                sel_entry, new_entry;

   assign dispatch_ready = (count_q < COUNT_W'(DEPTH));
   assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
   assign issue_fire     = issue_valid && issue_ready && !flush;
   assign queue_count    = count_q;

   // Hazards are evaluated on registered state only, so wakeup trails writeback by a cycle.
   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = entries_q[i].valid
                     && !(entries_q[i].use_rs1  && busy_q[entries_q[i].rs1])
                     && !(entries_q[i].use_rs2  && busy_q[entries_q[i].rs2])
                     && !(entries_q[i].write_rd && busy_q[entries_q[i].rd]);
         for (int j = 0; j < i; j++) begin
            if (order_conflict(entries_q[j], entries_q[i])) ready_vec[i] = 1'b0;
         end
      end
   end

   issue_select #(.DEPTH(DEPTH)) u_select (
      .ready_vec (ready_vec),
      .grant     (grant),
      .any_ready (any_ready)
   );

   always_comb begin
      sel_entry = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) sel_entry = sel_entry | entries_q[i];
      end
   end

   assign issue_valid  = any_ready;
   assign issue_packet = sel_entry.packet;

   // Register x0 is never a hazard: its use flags are dropped on the way in.
   always_comb begin
      new_entry          = '0;
      new_entry.valid    = 1'b1;
      new_entry.packet   = dispatch_packet;
      new_entry.rs1      = dispatch_rs1;
      new_entry.rs2      = dispatch_rs2;
      new_entry.rd       = dispatch_rd;
      new_entry.use_rs1  = dispatch_use_rs1  && (dispatch_rs1 != '0);
      new_entry.use_rs2  = dispatch_use_rs2  && (dispatch_rs2 != '0);
      new_entry.write_rd = dispatch_write_rd && (dispatch_rd  != '0);
   end

   // Entries at and above the granted slot move down one; the new op lands after the collapse.
   always_comb begin
      shift = '0;
      carry = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         carry    = carry | (grant[i] & issue_fire);
         shift[i] = carry;
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         entries_n[i] = shift[i] ? entries_q[i+1] : entries_q[i];
      end
      entries_n[DEPTH-1] = shift[DEPTH-1] ? '0 : entries_q[DEPTH-1];
      ins_idx = count_q - COUNT_W'(issue_fire);
      if (dispatch_fire) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ins_idx == COUNT_W'(i)) entries_n[i] = new_entry;
         end
      end
      count_n = ins_idx + COUNT_W'(dispatch_fire);
   end

   // Issue marking a register busy outranks a same-cycle writeback of that register.
   always_comb begin
      busy_n = busy_q;
      if (wb_valid) busy_n[wb_rd] = 1'b0;
      if (issue_fire && sel_entry.write_rd) busy_n[sel_entry.rd] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         count_q <= '0;
         busy_q  <= '0;
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      end else begin
         count_q <= count_n;
         busy_q  <= busy_n;
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_n[i];
      end
   end

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Directed bench for issue_queue_scheduler: hazards, out-of-order issue, full, flush, reset.
module tb_issue_queue_scheduler;
   localparam int PW = 130;

   logic          clock = 1'b0;
   logic          reset;
   logic          dispatch_valid, dispatch_ready;
   logic [PW-1:0] dispatch_packet;
   logic [4:0]    dispatch_rs1, dispatch_rs2, dispatch_rd;
   logic          dispatch_use_rs1, dispatch_use_rs2, dispatch_write_rd;
   logic          issue_valid, issue_ready;
   logic [PW-1:0] issue_packet;
   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic          flush;
   logic [3:0]    queue_count;

   int n_checks = 0;
   int n_fail   = 0;

   issue_queue_scheduler dut (
      .clock             (clock),
      .reset             (reset),
      .dispatch_valid    (dispatch_valid),
      .dispatch_ready    (dispatch_ready),
      .dispatch_packet   (dispatch_packet),
      .dispatch_rs1      (dispatch_rs1),
      .dispatch_rs2      (dispatch_rs2),
      .dispatch_rd       (dispatch_rd),
      .dispatch_use_rs1  (dispatch_use_rs1),
      .dispatch_use_rs2  (dispatch_use_rs2),
      .dispatch_write_rd (dispatch_write_rd),
      .issue_valid       (issue_valid),
      .issue_ready       (issue_ready),
      .issue_packet      (issue_packet),
      .wb_valid          (wb_valid),
      .wb_rd             (wb_rd),
      .flush             (flush),
      .queue_count       (queue_count)
   );

   always #5 clock = ~clock;

   function automatic logic [PW-1:0] mkp(input int k);
      return {2'b10, 32'(k), 32'hCAFE0000 + 32'(k), 32'(k * 7), 32'(k)};
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic disp(input int k, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr);
      dispatch_valid    = 1'b1;
      dispatch_packet   = mkp(k);
      dispatch_rs1      = rs1;
      dispatch_use_rs1  = u1;
      dispatch_rs2      = rs2;
      dispatch_use_rs2  = u2;
      dispatch_rd       = rd;
      dispatch_write_rd = wr;
   endtask

   task automatic idle();
      dispatch_valid    = 1'b0;
      dispatch_packet   = '0;
      dispatch_rs1      = '0;
      dispatch_rs2      = '0;
      dispatch_rd       = '0;
      dispatch_use_rs1  = 1'b0;
      dispatch_use_rs2  = 1'b0;
      dispatch_write_rd = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b1; issue_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
      repeat (2) cyc();
      reset = 1'b0;
      #1;
      chk("rst_count", queue_count, 0);
      chk("rst_dready", dispatch_ready, 1);
      chk("rst_ivalid", issue_valid, 0);
      chk("rst_ipacket", issue_packet, 0);

      // ADDI x1 <- x0: no same-cycle bypass, issues the cycle after dispatch
      disp(1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1);
      #1 chk("t1_no_bypass", issue_valid, 0);
      cyc(); idle(); #1;
      chk("t1_count1", queue_count, 1);
      chk("t1_ivalid", issue_valid, 1);
      chk("t1_packet", issue_packet, mkp(1));
      issue_ready = 1'b1;
      cyc(); issue_ready = 1'b0; #1;
      chk("t1_count0", queue_count, 0);
      chk("t1_empty_ivalid", issue_valid, 0);

      // ADD x2 = x1 + x3 held until wb of x1, visible the cycle after
      disp(2, 5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1);
      cyc(); idle(); #1;
      chk("t2_count", queue_count, 1);
      chk("t2_held", issue_valid, 0);
      issue_ready = 1'b1;
      cyc();
      chk("t2_still_held", issue_valid, 0);
      wb_valid = 1'b1; wb_rd = 5'd1;
      #1 chk("t2_wb_same_cycle", issue_valid, 0);
      cyc(); wb_valid = 1'b0; #1;
      chk("t2_wakeup", issue_valid, 1);
      chk("t2_packet", issue_packet, mkp(2));
      cyc(); issue_ready = 1'b0; #1;
      chk("t2_drained", queue_count, 0);

      // Out-of-order: [x5<-x1 (x1 busy), x6<-x7]
      disp(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
      cyc(); idle(); issue_ready = 1'b1;
      cyc(); issue_ready = 1'b0;
      disp(4, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      cyc();
      disp(5, 5'd7, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
      cyc(); idle(); #1;
      chk("t3_count2", queue_count, 2);
      chk("t3_ivalid", issue_valid, 1);
      chk("t3_ooo_packet", issue_packet, mkp(5));
      issue_ready = 1'b1;
      cyc(); issue_ready = 1'b0; #1;
      chk("t3_count1", queue_count, 1);
      chk("t3_head_blocked", issue_valid, 0);
      wb_valid = 1'b1; wb_rd = 5'd1;
      cyc(); wb_valid = 1'b0; #1;
      chk("t3_collapsed_packet", issue_packet, mkp(4));
      issue_ready = 1'b1;
      cyc(); issue_ready = 1'b0; #1;
      chk("t3_drained", queue_count, 0);

      // WAR: [x8 <- x4 + x2 (x2 busy), x4 <- x9]
      disp(6, 5'd4, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1);
      cyc();
      disp(7, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
      cyc(); idle(); #1;
      chk("t4_count2", queue_count, 2);
      chk("t4_war_held", issue_valid, 0);
      wb_valid = 1'b1; wb_rd = 5'd2;
      cyc(); wb_valid = 1'b0; #1;
      chk("t4_older_first", issue_packet, mkp(6));
      issue_ready = 1'b1;
      cyc();
      chk("t4_count1", queue_count, 1);
      chk("t4_younger_free", issue_valid, 1);
      chk("t4_younger_packet", issue_packet, mkp(7));
      cyc(); issue_ready = 1'b0; #1;
      chk("t4_drained", queue_count, 0);

      // Fill to DEPTH with independent ops
      for (int k = 10; k < 18; k++) begin
         disp(k, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
         cyc();
      end
      disp(18, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("t5_full_count", queue_count, 8);
      chk("t5_full_dready", dispatch_ready, 0);
      chk("t5_head_packet", issue_packet, mkp(10));
      issue_ready = 1'b1;
      #1 chk("t5_no_reopen", dispatch_ready, 0);
      cyc(); idle(); issue_ready = 1'b0; #1;
      chk("t5_count7", queue_count, 7);
      chk("t5_reopened", dispatch_ready, 1);
      chk("t5_next_head", issue_packet, mkp(11));
      disp(19, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      issue_ready = 1'b1;
      cyc(); idle(); issue_ready = 1'b0; #1;
      chk("t5_issue_disp_count", queue_count, 7);
      chk("t5_issue_disp_head", issue_packet, mkp(12));
      issue_ready = 1'b1;
      cyc(); cyc(); issue_ready = 1'b0; #1;
      chk("t5_count5", queue_count, 5);
      chk("t5_head14", issue_packet, mkp(14));

      // Flush with count 5 and same-cycle dispatch + issue
      flush = 1'b1; issue_ready = 1'b1;
      disp(20, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 chk("t6_ivalid_during_flush", issue_valid, 1);
      cyc(); flush = 1'b0; issue_ready = 1'b0; idle(); #1;
      chk("t6_count0", queue_count, 0);
      chk("t6_ivalid0", issue_valid, 0);
      chk("t6_dready", dispatch_ready, 1);
      disp(21, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
      cyc(); idle(); #1;
      chk("t6_scoreboard_clear", issue_valid, 1);
      chk("t6_packet", issue_packet, mkp(21));

      // Reset mid-operation with a dispatch in flight
      disp(22, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
      reset = 1'b1;
      cyc(); reset = 1'b0; idle(); #1;
      chk("mid_rst_count", queue_count, 0);
      chk("mid_rst_ivalid", issue_valid, 0);
      chk("mid_rst_ipacket", issue_packet, 0);

      // Issue setting x3 busy wins over a same-cycle wb of x3
      disp(23, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
      cyc(); idle();
      issue_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3;
      cyc(); issue_ready = 1'b0; wb_valid = 1'b0;
      disp(24, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      cyc(); idle(); #1;
      chk("set_wins_count", queue_count, 1);
      chk("set_wins_held", issue_valid, 0);
      wb_valid = 1'b1; wb_rd = 5'd3;
      cyc(); wb_valid = 1'b0; #1;
      chk("set_wins_wakeup", issue_packet, mkp(24));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
